// File: rtl/prim_fifo_credit_pkg.sv
// Shared types and width helpers for the producer-side FIFO credit counter.
// The credit counter width is derived from the remote FIFO depth.
package prim_fifo_credit_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StActive = 2'd2,
    StError  = 2'd3
  } cred_state_e;

  // Bits needed to represent values 0..v-1, never less than one.
  function automatic int unsigned vbits(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  // Credit counter width: must hold every value in [0, depth].
  function automatic int unsigned cred_w(input int unsigned depth);
    return vbits(depth + 1);
  endfunction

endpackage

// File: rtl/prim_fifo_credit_cnt_count.sv
// Hardened up/down counter: a primary count plus an independently updated
// inverted shadow; any disagreement between the two raises err_o.
module prim_fifo_credit_cnt_count #(
  parameter int unsigned      Width  = 3,
  parameter logic [Width-1:0] SetVal = '0,
  parameter bit               ClrEn  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             set_i,
  input  logic             incr_i,
  input  logic             decr_i,
  output logic [Width-1:0] cnt_o,
  output logic             err_o
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width-1:0] inv_q, inv_d;

  // The shadow moves in the opposite direction so a single stuck or flipped
  // bit in either register cannot keep the pair consistent.
  always_comb begin
    cnt_d = cnt_q;
    inv_d = inv_q;
    if (ClrEn && clr_i) begin
      cnt_d = '0;
      inv_d = '1;
    end else if (set_i) begin
      cnt_d = SetVal;
      inv_d = ~SetVal;
    end else if (incr_i && !decr_i) begin
      cnt_d = cnt_q + Width'(1);
      inv_d = inv_q - Width'(1);
    end else if (decr_i && !incr_i) begin
      cnt_d = cnt_q - Width'(1);
      inv_d = inv_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      inv_q <= '1;
    end else begin
      cnt_q <= cnt_d;
      inv_q <= inv_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = (cnt_q != ~inv_q);

endmodule

// File: rtl/prim_fifo_credit_cnt.sv
// Producer-side credit counter for a same-clock downstream FIFO: spends one
// credit per word sent, regains one per consumer pop, never lets the FIFO overflow.
module prim_fifo_credit_cnt
  import prim_fifo_credit_pkg::*;
#(
  parameter int unsigned Depth       = 4,
  parameter bit          Secure      = 1'b0,
  parameter bit          NeverClears = 1'b0,
  localparam int unsigned CW         = cred_w(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic          valid_o,
  input  logic          credit_ret_i,
  output logic [CW-1:0] credits_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          err_o
);

  localparam logic [CW-1:0] DepthC = CW'(Depth);

  cred_state_e   state_q, state_d;
  logic          loaded_q, loaded_d;
  logic [CW-1:0] credits;
  logic          cnt_err;
  logic          clr_eff, send, ret, count_en, overflow, err_entry, upd_ok;
  logic          cnt_clr, cnt_set, cnt_incr, cnt_decr;

  assign clr_eff = clr_i & ~NeverClears;
  assign ready_o = (state_q == StActive) & (credits != '0) & en_i;
  assign send    = valid_i & ready_o;
  assign valid_o = send;

  // Returns keep counting in StIdle once credits have been loaded, so words
  // popped after the link is disabled are not lost.
  assign count_en  = (state_q == StActive) | ((state_q == StIdle) & loaded_q);
  assign ret       = credit_ret_i & count_en;
  assign overflow  = ret & ~send & (credits == DepthC);
  assign err_entry = (overflow | cnt_err) & (state_q != StError);

  assign upd_ok   = ~clr_eff & ~err_entry & count_en;
  assign cnt_clr  = clr_eff;
  assign cnt_set  = ~clr_eff & ~err_entry & (state_q == StLoad);
  assign cnt_incr = upd_ok & ret & ~send;
  assign cnt_decr = upd_ok & send & ~ret;

  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q;
    if (clr_eff) begin
      state_d  = StIdle;
      loaded_d = 1'b0;
    end else if (state_q == StError) begin
      state_d = StError;
    end else if (err_entry) begin
      state_d = StError;
    end else begin
      case (state_q)
        StIdle:   if (en_i) state_d = loaded_q ? StActive : StLoad;
        StLoad: begin
          state_d  = StActive;
          loaded_d = 1'b1;
        end
        StActive: if (!en_i) state_d = StIdle;
        default:  state_d = StError;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
    end
  end

  if (Secure) begin : gen_secure
    prim_fifo_credit_cnt_count #(
      .Width  (CW),
      .SetVal (DepthC),
      .ClrEn  (!NeverClears)
    ) u_count (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (cnt_clr),
      .set_i  (cnt_set),
      .incr_i (cnt_incr),
      .decr_i (cnt_decr),
      .cnt_o  (credits),
      .err_o  (cnt_err)
    );
  end else begin : gen_plain
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)       cnt_q <= '0;
      else if (cnt_clr)  cnt_q <= '0;
      else if (cnt_set)  cnt_q <= DepthC;
      else if (cnt_incr) cnt_q <= cnt_q + CW'(1);
      else if (cnt_decr) cnt_q <= cnt_q - CW'(1);
    end
    assign credits = cnt_q;
    assign cnt_err = 1'b0;
  end

  assign credits_o = credits;
  assign full_o    = (credits == DepthC);
  assign empty_o   = (credits == '0);
  assign err_o     = (state_q == StError);

endmodule
